div_radix2: RTL and testbench
=============================

DIV_RADIX2 -- requirements
Module: div_radix2

Interface
- REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
- REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (asserted when 0).
- REQ-003 SHALL have port in_valid, input, 1 bit: requester presents an operation.
- REQ-004 SHALL have port in_ready, output, 1 bit: block can accept an operation (high only in IDLE).
- REQ-005 SHALL have port sign, input, 1 bit: 1 = signed (two's complement) divide, 0 = unsigned.
- REQ-006 SHALL have port a, input, 32 bits: dividend.
- REQ-007 SHALL have port b, input, 32 bits: divisor.
- REQ-008 SHALL have port flush, input, 1 bit: abort the current operation.
- REQ-009 SHALL have port out_valid, output, 1 bit: result available.
- REQ-010 SHALL have port out_ready, input, 1 bit: requester consumes the result.
- REQ-011 SHALL have port quotient, output, 32 bits: final signed-corrected quotient.
- REQ-012 SHALL have port remainder, output, 32 bits: final signed-corrected remainder.
- REQ-013 SHALL have port stallreq, output, 1 bit: pipeline stall request, high from the accept cycle until the result handshake.

Function
- REQ-014 SHALL accept an operation on the cycle T where in_valid & in_ready; it SHALL latch a, b, sign, sign(a) and sign(a)^sign(b) at T.
- REQ-015 SHALL implement the states IDLE -> PREP -> CALC -> FIX -> DONE -> IDLE.
- REQ-016 PREP (T+1): take the absolute values of the operands when sign=1; clear the partial remainder; load the iteration counter with 31.
- REQ-017 CALC (T+2..T+33): perform one restoring step per cycle (shift, trial subtract, set the quotient bit when the difference is non-negative); the counter decrements and CALC exits when the counter reaches 0.
- REQ-018 FIX (T+34): negate the quotient if the latched sign XOR =1 and sign=1; negate the remainder if the latched sign(a)=1 and sign=1.
- REQ-019 DONE: out_valid=1 from T+35; quotient and remainder SHALL hold stable until out_ready=1; the handshake cycle returns the block to IDLE.
- REQ-020 SHALL drive stallreq = in_valid in IDLE; in other states stallreq = ~(DONE & out_ready).
- REQ-021 Divide by zero (b=0): quotient = 32'hFFFFFFFF, remainder = a, regardless of sign.
- REQ-022 Signed overflow (a=32'h80000000, b=32'hFFFFFFFF, sign=1): quotient = 32'h80000000, remainder = 0.
- REQ-023 flush=1 in any state SHALL force IDLE on the next edge and deassert out_valid; flush wins over a simultaneous accept.
- REQ-024 in_valid SHALL be ignored outside IDLE; no operation queueing.

Reset
- REQ-025 When reset is asserted: state=IDLE, in_ready=1, out_valid=0, stallreq=0, quotient=0, remainder=0, counter=0; applies immediately, including mid-operation.
- REQ-026 After reset deassertion, the first accept is allowed on the first rising edge.

Configuration
- REQ-027 Macro DIV_FAST_PATH_EN defined: when, at PREP, b=0 or |a|<|b|, the block SHALL skip CALC and FIX and enter DONE at T+2 with the REQ-021 result or (quotient=0, remainder=a).
- REQ-028 Macro DIV_FAST_PATH_EN undefined: every operation SHALL take the full latency; out_valid at T+35.

Structure
- REQ-029 Package mul_div_pkg SHALL hold the state enum typedef, DIV_WIDTH=32, DIV_ITERS=32 and the divide-by-zero quotient constant.
- REQ-030 A single combinational sub-module div_abs (conditional two's-complement magnitude) SHALL be instantiated twice, for the operands in PREP and for the results in FIX.

Verification
- REQ-031 Unsigned a=100, b=7 -> quotient=14, remainder=2, out_valid at T+35.
- REQ-032 Signed a=-7 (32'hFFFFFFF9), b=2 -> quotient=-3 (32'hFFFFFFFD), remainder=-1 (32'hFFFFFFFF).
- REQ-033 a=5, b=0 (either sign) -> quotient=32'hFFFFFFFF, remainder=5; with DIV_FAST_PATH_EN the result arrives at T+2.
- REQ-034 Signed a=32'h80000000, b=-1 -> quotient=32'h80000000, remainder=0.
- REQ-035 flush at T+10 -> IDLE at T+11 with in_ready=1 and out_valid never asserted; a new 9/3 operation then returns quotient=3, remainder=0.
- REQ-036 out_ready held low for 5 cycles in DONE -> outputs stable and stallreq=1 throughout; reset asserted at T+20 -> all outputs take their REQ-025 values immediately.

Source files
------------

// File: rtl/mul_div_pkg.sv
// Shared types and constants for the radix-2 restoring divider.
package mul_div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = $clog2(DIV_ITERS);

    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        CALC,
        FIX,
        DONE
    } div_state_t;

endpackage

// File: rtl/div_abs.sv
// Combinational conditional two's-complement negation, one lane per value.
module div_abs #(
    parameter int W = 32,
    parameter int N = 2
) (
    input  logic [N-1:0][W-1:0] din,
    input  logic [N-1:0]        neg,
    output logic [N-1:0][W-1:0] dout
);

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign dout[i] = neg[i] ? -din[i] : din[i];
    end

endmodule

// File: rtl/div_radix2.sv
// 32-bit radix-2 restoring divider, signed/unsigned, with flush and stall request.
// Define DIV_FAST_PATH_EN to finish early when b==0 or |a|<|b|.
module div_radix2
    import mul_div_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        sign,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        stallreq
);

    div_state_t state, state_nx;

    logic [DIV_WIDTH-1:0] a_q, b_q, dvd, dvs, rem, diff;
    logic [DIV_WIDTH:0]   shifted;
    logic [CNT_W-1:0]     cnt;
    logic                 sign_q, a_neg_q, qneg_q;
    logic                 ge, b_zero, fast;

    logic [1:0][DIV_WIDTH-1:0] op_in, op_abs, res_in, res_fix;
    logic [1:0]                op_neg, res_neg;

    // lane 0 = dividend / quotient, lane 1 = divisor / remainder
    assign op_in   = {b_q, a_q};
    assign op_neg  = {sign_q & b_q[DIV_WIDTH-1], sign_q & a_neg_q};
    assign res_in  = {rem, dvd};
    assign res_neg = {sign_q & a_neg_q, sign_q & qneg_q};

    div_abs #(.W(DIV_WIDTH), .N(2)) u_abs_op (
        .din (op_in),
        .neg (op_neg),
        .dout(op_abs)
    );

    div_abs #(.W(DIV_WIDTH), .N(2)) u_abs_res (
        .din (res_in),
        .neg (res_neg),
        .dout(res_fix)
    );

    // Restoring step: the dividend register doubles as the quotient shift-in.
    assign shifted = {rem, dvd[DIV_WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs};
    assign diff    = shifted[DIV_WIDTH-1:0] - dvs;
    assign b_zero  = (b_q == '0);

`ifdef DIV_FAST_PATH_EN
    assign fast = b_zero || (op_abs[0] < op_abs[1]);
`else
    assign fast = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        stallreq  = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                stallreq = in_valid & reset;
                if (in_valid) state_nx = PREP;
            end
            PREP: state_nx = fast ? DONE : CALC;
            CALC: if (cnt == '0) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                stallreq  = ~out_ready;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) state_nx = IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q       <= '0;
            b_q       <= '0;
            sign_q    <= 1'b0;
            a_neg_q   <= 1'b0;
            qneg_q    <= 1'b0;
            dvd       <= '0;
            dvs       <= '0;
            rem       <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
        end else if (!flush) begin
            case (state)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    sign_q  <= sign;
                    a_neg_q <= a[DIV_WIDTH-1];
                    qneg_q  <= a[DIV_WIDTH-1] ^ b[DIV_WIDTH-1];
                end
                PREP: begin
                    dvd <= op_abs[0];
                    dvs <= op_abs[1];
                    rem <= '0;
                    cnt <= CNT_W'(DIV_ITERS - 1);
                    if (fast) begin
                        quotient  <= b_zero ? DIV_ZERO_Q : '0;
                        remainder <= a_q;
                    end
                end
                CALC: begin
                    rem <= ge ? diff : shifted[DIV_WIDTH-1:0];
                    dvd <= {dvd[DIV_WIDTH-2:0], ge};
                    cnt <= cnt - CNT_W'(1);
                end
                FIX: begin
                    // Divide by zero reports the raw dividend regardless of sign.
                    quotient  <= b_zero ? DIV_ZERO_Q : res_fix[0];
                    remainder <= b_zero ? a_q : res_fix[1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix2.sv
// Scoreboard bench for div_radix2: directed vectors, queue of expected results.
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        sign = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, stallreq;
    logic [31:0] quotient, remainder;

`ifdef DIV_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          acc;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   fails = 0;
    int   cyc = 0;
    bit   prev_valid = 1'b0;

    div_radix2 dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sign     (sign),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient (quotient),
        .remainder(remainder),
        .stallreq (stallreq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: compare the first cycle of every presented result.
    always @(negedge clk) begin
        if (out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            end
        end
        prev_valid = out_valid;
    end

    task automatic issue(input logic s, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] eq, input logic [31:0] er, input bit fp);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_timeout", 32'd0, 32'd1);
        sign = s;
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_q.push_back('{q: eq, r: er, acc: cyc, lat: (FAST && fp) ? 2 : 35});
    endtask

    task automatic collect(input int hold);
        int n = 0;
        logic [31:0] hq, hr;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        hq = quotient;
        hr = remainder;
        repeat (hold) begin
            chk("hold_stallreq", 32'(stallreq), 32'd1);
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_quotient", quotient, hq);
            chk("hold_remainder", remainder, hr);
        end
        out_ready = 1'b1;
        #1;
        chk("handshake_stallreq", 32'(stallreq), 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_handshake_valid", 32'(out_valid), 32'd0);
        chk("post_handshake_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input logic s, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] eq, input logic [31:0] er, input bit fp);
        issue(s, av, bv, eq, er, fp);
        collect(0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_stallreq", 32'(stallreq), 32'd0);
        chk("reset_quotient", quotient, 32'd0);
        chk("reset_remainder", remainder, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        //   sign  a             b             quotient      remainder     fast
        run(1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0);
        run(1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        run(1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1);
        run(1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1);
        run(1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1);
        run(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0);
        run(1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b1);
        run(1'b0, 32'd3,        32'd10,       32'd0,        32'd3,        1'b1);
        run(1'b1, 32'hFFFFFFFD, 32'd10,       32'd0,        32'hFFFFFFFD, 1'b1);
        run(1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0);
        run(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE, 1'b0);
        run(1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0);
        run(1'b0, 32'hFFFFFFFF, 32'd10,       32'h19999999, 32'd5,        1'b0);

        // Flush at T+10 aborts; no result may appear afterwards.
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", 32'(seen), 32'd0);
        run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Flush beats a simultaneous accept.
        @(negedge clk);
        sign = 1'b0;
        a = 32'd40;
        b = 32'd4;
        in_valid = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
        chk("flush_vs_accept_ready", 32'(in_ready), 32'd1);

        // Result held with out_ready low for 5 cycles.
        issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        collect(5);

        // Asynchronous reset mid-operation at T+20.
        issue(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        repeat (19) @(posedge clk);
        #1;
        chk("busy_stallreq", 32'(stallreq), 32'd1);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_in_ready", 32'(in_ready), 32'd1);
        chk("async_reset_out_valid", 32'(out_valid), 32'd0);
        chk("async_reset_stallreq", 32'(stallreq), 32'd0);
        chk("async_reset_quotient", quotient, 32'd0);
        chk("async_reset_remainder", remainder, 32'd0);
        exp_q.delete(exp_q.size() - 1);
        @(negedge clk);
        reset = 1'b1;
        run(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
